sub_bytes_serial: RTL and testbench

Byte-serial AES-128 SubBytes engine that sits directly upstream of the shared `sbox` lookup and consumes its output. It accepts a 128-bit state over a valid/ready handshake and presents one state byte per cycle to a single combinational `sbox` instance (`index` in, `o` out). It collects the 16 substituted bytes and returns the transformed state over a second valid/ready handshake. The serial structure trades throughput for area: one S-box replaces sixteen, for the iterative round datapath.

---
 rtl/sub_bytes_serial.sv | 174 +++++++++++++++++
 tb/tb_sub_bytes_serial.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: byte-serial AES-128 SubBytes engine.
// A 128-bit state is accepted on an in_valid/in_ready handshake. The engine
// then feeds one byte per cycle through a single combinational sbox. After
// 16 cycles it presents the substituted state on an out_valid/out_ready
// handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   in_valid   in   upstream presents in_data
//   in_ready   out  engine idle and able to accept a state (registered)
//   in_data    in   [127:0] state, byte k = in_data[127-8k -: 8], column-major
//   out_valid  out  out_data holds a finished result (registered)
//   out_ready  in   downstream accepts out_data
//   out_data   out  [127:0] transformed state, same byte order as in_data
//   busy       out  high while running or holding a result
//
// Build option: defining SUB_BYTES_SHIFTROWS_EN fuses the ShiftRows byte
// permutation into the result write address. out_data is then
// ShiftRows(SubBytes(in_data)). Latency and handshakes are unchanged.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a state, in_ready=1
// RUN   | one byte per cycle through the sbox, cnt = byte index 0..15
// DONE  | result held, out_valid=1 until out_ready

module sub_bytes_serial (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] src;
  logic [127:0] res;
  logic [7:0]   sb_index;
  logic [7:0]   sb_o;
  logic [3:0]   dst;

  // Source byte select for the current count.
  always_comb begin
    sb_index = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (cnt == i[3:0]) sb_index = src[127-8*i -: 8];
    end
  end

`ifdef SUB_BYTES_SHIFTROWS_EN
  // Byte at row r, column c lands in column (c - r) mod 4 of the same row.
  // The 2-bit subtraction wraps, which gives the mod-4 result directly.
  always_comb begin
    dst = {cnt[3:2] - cnt[1:0], cnt[1:0]};
  end
`else
  always_comb begin
    dst = cnt;
  end
`endif

  sbox u_sbox (
    .index (sb_index),
    .o     (sb_o)
  );

  // Outputs are registered. in_ready comes up one cycle after reset release,
  // so no accept can happen on the first edge out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      src       <= 128'h0;
      res       <= 128'h0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            src      <= in_data;
            cnt      <= 4'd0;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          for (int i = 0; i < 16; i++) begin
            if (dst == i[3:0]) res[127-8*i -: 8] <= sb_o;
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = res;

endmodule

// sbox: combinational AES S-box.
// It computes the multiplicative inverse in GF(2^8) as x^254 and then applies
// the AES affine transform. This matches the 256-entry table without storing
// one.
//   index  in   [7:0] input byte
//   o      out  [7:0] substituted byte
module sbox (
  input  logic [7:0] index,
  output logic [7:0] o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] pw;
  logic [7:0] inv;

  // Successive squarings accumulate x^(2+4+...+128) = x^254 = x^-1.
  // The zero input maps to zero.
  always_comb begin
    pw  = index;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
module tb_sub_bytes_serial;

  localparam logic [7:0] SBOX_T [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

`ifdef SUB_BYTES_SHIFTROWS_EN
  localparam logic [127:0] FIPS_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`else
  localparam logic [127:0] FIPS_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  sub_bytes_serial dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: substitute every byte through the table. With the build
  // option, move byte (row r, column c) to column (c - r) mod 4.
  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    int pos;
    r = '0;
    for (int k = 0; k < 16; k++) begin
`ifdef SUB_BYTES_SHIFTROWS_EN
      pos = (k % 4) + 4 * (((k / 4) - (k % 4) + 4) % 4);
`else
      pos = k;
`endif
      r[127-8*pos -: 8] = SBOX_T[d[127-8*k -: 8]];
    end
    return r;
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge
  logic [127:0] expq[$];
  logic [127:0] outs_log[$];
  int           acc_log[$];
  bit           inflight = 1'b0;
  int           acc_edge = 0;
  int           n_out = 0;

  always @(negedge clk) begin
    if (resetn !== 1'b1) begin
      expq.delete();
      inflight = 1'b0;
      chk("rst_in_ready", {127'b0, in_ready}, 128'h0);
      chk("rst_out_valid", {127'b0, out_valid}, 128'h0);
      chk("rst_busy", {127'b0, busy}, 128'h0);
      chk("rst_out_data", out_data, 128'h0);
    end else begin
      chk("busy", {127'b0, busy}, {127'b0, inflight});
      chk("out_valid", {127'b0, out_valid}, {127'b0, inflight && (cyc >= acc_edge + 16)});
      if (inflight) chk("in_ready_blocked", {127'b0, in_ready}, 128'h0);
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", {127'b0, out_valid}, 128'h0);
        end else begin
          chk("out_data", out_data, expq[0]);
          if (out_ready) begin
            outs_log.push_back(out_data);
            void'(expq.pop_front());
            inflight = 1'b0;
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(in_data));
        inflight = 1'b1;
        acc_edge = cyc + 1;
        acc_log.push_back(cyc + 1);
      end
    end
  end

  task automatic run_block(input logic [127:0] d, input int pre_idle, input int stall,
                           output logic [127:0] got);
    bit ok;
    repeat (pre_idle) @(posedge clk);
    #1;
    in_data  = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 128'h0, 128'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("out_valid_timeout", 128'h0, 128'h1);
    got = out_data;
    repeat (stall) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] d;
    logic [127:0] snap_d;
    int base;
    int nacc;
    bit ok;

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    resetn    = 1'b1;
    #1 resetn = 1'b0;
    #2;
    chk("reset_in_ready", {127'b0, in_ready}, 128'h0);
    chk("reset_out_data", out_data, 128'h0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;

    // The reference model is pinned to hand-computed values.
    chk("model_zero", model(128'h0), {16{8'h63}});
    chk("model_fips", model(128'h193de3bea0f4e22b9ac68d2ae9f84808), FIPS_EXP);
    chk("model_ones", model({16{8'h01}}), {16{8'h7c}});
    chk("model_ff", model({16{8'hff}}), {16{8'h16}});

    run_block(128'h0, 1, 0, got);
    chk("zero_block", got, {16{8'h63}});
    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, 2, got);
    chk("fips_block", got, FIPS_EXP);

    // Backpressure: result held for 50 cycles with in_valid asserted.
    @(posedge clk);
    #1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("bp_out_valid_timeout", 128'h0, 128'h1);
    snap_d = out_data;
    @(posedge clk);
    #1 in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_data !== snap_d || out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
        chk("bp_stable", {out_data, out_valid, busy, in_ready}, {snap_d, 3'b110});
    end
    chk("bp_final_data", out_data, snap_d);
    @(posedge clk);
    #1 in_valid = 1'b0;
    base = n_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_one_handshake", 128'(n_out - base), 128'h1);

    // Back-to-back: in_valid and out_ready held high for two blocks.
    @(posedge clk);
    #1;
    in_data   = {16{8'h00}};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    nacc = 0;
    for (int i = 0; i < 100 && nacc < 2; i++) begin
      @(negedge clk);
      if (in_ready) begin
        nacc++;
        @(posedge clk);
        #1;
        if (nacc == 1) in_data = {16{8'hff}};
        else in_valid = 1'b0;
      end
    end
    chk("b2b_accepts", 128'(nacc), 128'h2);
    for (int i = 0; i < 100 && n_out < base + 2; i++) @(negedge clk);
    chk("b2b_outputs", 128'(n_out - base), 128'h2);
    @(posedge clk);
    #1 out_ready = 1'b0;
    if (acc_log.size() >= 2 && outs_log.size() >= 2) begin
      chk("b2b_interval", 128'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 128'd18);
      chk("b2b_out0", outs_log[outs_log.size()-2], {16{8'h63}});
      chk("b2b_out1", outs_log[outs_log.size()-1], {16{8'h16}});
    end else begin
      chk("b2b_logs", 128'(acc_log.size()), 128'h2);
    end

    // Mid-run reset with cnt at 7.
    @(posedge clk);
    #1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("mr_accept_timeout", 128'h0, 128'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mr_out_valid", {127'b0, out_valid}, 128'h0);
    chk("mr_busy", {127'b0, busy}, 128'h0);
    chk("mr_in_ready", {127'b0, in_ready}, 128'h0);
    chk("mr_out_data", out_data, 128'h0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    run_block({16{8'h01}}, 0, 1, got);
    chk("mr_fresh_block", got, {16{8'h7c}});

    // Sweep of all byte values across 16 blocks.
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = 8'(16 * b + k);
      run_block(d, 0, 0, got);
    end

    // Random blocks with random idle and stall gaps.
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), got);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 128'(expq.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
